// File: rtl/tone_generator.sv
// tone_generator: synchronises and stability-filters the encoder note code,
// looks up a half-period divider and toggles a 50% square wave on spk.
//
// Code format: bit4 = high octave, bit3 = low octave, bits[2:0] = note 0..6.
// 5'b11111 is silence; bits[2:0]==7 or bit4&bit3 together are illegal and
// behave as silence (note_valid=0, spk held low).
module tone_generator #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int DIV_W      = 18,
  parameter int STABLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] signal,
  output logic       spk,
  output logic       note_valid,
  output logic [4:0] cur_code
);

  localparam int SCW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYC - 1);

  typedef enum logic {SILENT = 1'b0, TONE = 1'b1} state_t;

  // Mid-octave half period for a note index, shifted for the octave bits.
  function automatic logic [DIV_W-1:0] hp_lookup(input logic [4:0] code);
    logic [DIV_W-1:0] mid;
    case (code[2:0])
      3'd0:    mid = DIV_W'(CLK_HZ / (2 * 262));
      3'd1:    mid = DIV_W'(CLK_HZ / (2 * 294));
      3'd2:    mid = DIV_W'(CLK_HZ / (2 * 330));
      3'd3:    mid = DIV_W'(CLK_HZ / (2 * 349));
      3'd4:    mid = DIV_W'(CLK_HZ / (2 * 392));
      3'd5:    mid = DIV_W'(CLK_HZ / (2 * 440));
      3'd6:    mid = DIV_W'(CLK_HZ / (2 * 494));
      default: mid = '0;
    endcase
    if (code[4])      hp_lookup = mid >> 1;
    else if (code[3]) hp_lookup = mid << 1;
    else              hp_lookup = mid;
  endfunction

  function automatic logic is_legal(input logic [4:0] code);
    is_legal = (code[2:0] != 3'b111) && !(code[4] && code[3]);
  endfunction

  logic [4:0]       r_sync1;
  logic [4:0]       r_sync2;
  logic [SCW-1:0]   r_stab;
  logic [4:0]       r_cur;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic             r_spk;
  logic             w_changed;
  logic             w_load;
  logic [DIV_W-1:0] w_hp;

  // r_sync1 holds the next synced sample, so a difference means r_sync2 is
  // about to change; the stability count then restarts on the same edge.
  assign w_changed = (r_sync1 != r_sync2);
  assign w_load    = (r_stab == STAB_LAST) && (r_sync2 != r_cur);
  assign w_hp      = hp_lookup(r_cur);

  // Two-flop synchroniser on the asynchronous code bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 5'b11111;
      r_sync2 <= 5'b11111;
    end else begin
      r_sync1 <= signal;
      r_sync2 <= r_sync1;
    end
  end

  // Stability counter (saturating) and accepted-code register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stab <= '0;
      r_cur  <= 5'b11111;
    end else begin
      if (w_changed)                r_stab <= '0;
      else if (r_stab != STAB_LAST) r_stab <= r_stab + 1'b1;
      if (w_load)                   r_cur  <= r_sync2;
    end
  end

  // Tone FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SILENT;
    else        r_state <= w_state_nxt;
  end

  // Tone FSM next state: a newly accepted code decides directly.
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = is_legal(r_sync2) ? TONE : SILENT;
    end else begin
      case (r_state)
        SILENT:  if (is_legal(r_cur))  w_state_nxt = TONE;
        TONE:    if (!is_legal(r_cur)) w_state_nxt = SILENT;
        default: w_state_nxt = SILENT;
      endcase
    end
  end

  // Half-period counter and square wave; a code change restarts both cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_spk <= 1'b0;
    end else if (w_load || r_state != TONE) begin
      r_cnt <= '0;
      r_spk <= 1'b0;
    end else if (r_cnt == w_hp - DIV_W'(1)) begin
      r_cnt <= '0;
      r_spk <= ~r_spk;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign spk        = r_spk;
  assign note_valid = (r_state == TONE);
  assign cur_code   = r_cur;

endmodule
